execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 32 +++
 rtl/execute_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-to-execute bundle plus writeback, redirect and HI/LO results
interface execute_stage_if #(
    parameter int data_width = 32
);
    logic                  enable_execute;
    logic [31:0]           pc_in;
    logic [5:0]            opcode_in;
    logic [5:0]            func_in;
    logic [4:0]            rt_in;
    logic [4:0]            rd_in;
    logic [4:0]            sa_in;
    logic [25:0]           imm_in;
    logic [data_width-1:0] rs_data;
    logic [data_width-1:0] rt_data;
    logic [data_width-1:0] result_out;
    logic [4:0]            dest_out;
    logic                  wb_out;
    logic [31:0]           pc_out;
    logic                  branch_taken;
    logic [31:0]           branch_target;
    logic                  stall;
    logic [data_width-1:0] hi_out;
    logic [data_width-1:0] lo_out;
    modport master (
        output enable_execute, pc_in, opcode_in, func_in, rt_in, rd_in, sa_in, imm_in, rs_data, rt_data,
        input  result_out, dest_out, wb_out, pc_out, branch_taken, branch_target, stall, hi_out, lo_out
    );
    modport slave (
        input  enable_execute, pc_in, opcode_in, func_in, rt_in, rd_in, sa_in, imm_in, rs_data, rt_data,
        output result_out, dest_out, wb_out, pc_out, branch_taken, branch_target, stall, hi_out, lo_out
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU/branch unit with iterative MULTU/DIVU feeding HI/LO
module execute_stage #(
    parameter int data_width = 32,
    parameter int md_cycles  = 32
) (
    input logic clock,
    input logic reset,
    execute_stage_if.slave bus
);
    localparam int w  = data_width;
    localparam int cw = $clog2(md_cycles) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;
    logic [w-1:0] a, b, sext, zext, res, md_b;
    logic [2*w-1:0] pr, pr_n;
    logic [w:0] sum, diff;
    logic [cw-1:0] cnt;
    logic [4:0] dest;
    logic [31:0] pc4, btgt, jtgt;
    logic wb_c, bt_c, is_br, is_j, md_mul, md_div, busy, last, accept;
    assign a      = bus.rs_data;
    assign b      = bus.rt_data;
    assign busy   = state == MUL || state == DIV;
    assign last   = busy && cnt == cw'(md_cycles - 1);
    assign accept = bus.enable_execute && !busy;
    assign sext   = {{(w-16){bus.imm_in[15]}}, bus.imm_in[15:0]};
    assign zext   = w'(bus.imm_in[15:0]);
    assign pc4    = bus.pc_in + 32'd4;
    assign btgt   = pc4 + {{14{bus.imm_in[15]}}, bus.imm_in[15:0], 2'b00};
    assign jtgt   = {pc4[31:28], bus.imm_in, 2'b00};
    // pr holds {acc, multiplier} for MULTU and {remainder, quotient} for DIVU
    assign sum    = {1'b0, pr[2*w-1:w]} + (pr[0] ? {1'b0, md_b} : '0);
    assign diff   = pr[2*w-1:w-1] - {1'b0, md_b};
    assign pr_n   = state == MUL ? {sum, pr[w-1:1]}
                  : diff[w] ? {pr[2*w-2:0], 1'b0} : {diff[w-1:0], pr[w-2:0], 1'b1};
    always_comb begin
        res    = '0;
        dest   = bus.rd_in;
        wb_c   = 1'b1;
        bt_c   = 1'b0;
        is_br  = 1'b0;
        is_j   = 1'b0;
        md_mul = 1'b0;
        md_div = 1'b0;
        if (bus.opcode_in == 6'b000000) begin
            case (bus.func_in)
                6'b100001: res = a + b;
                6'b100011: res = a - b;
                6'b100100: res = a & b;
                6'b100101: res = a | b;
                6'b100110: res = a ^ b;
                6'b100111: res = ~(a | b);
                6'b101010: res = {{(w-1){1'b0}}, $signed(a) < $signed(b)};
                6'b101011: res = {{(w-1){1'b0}}, a < b};
                6'b000000: res = b << bus.sa_in;
                6'b000010: res = b >> bus.sa_in;
                6'b000011: res = $signed(b) >>> bus.sa_in;
                6'b010000: res = bus.hi_out;
                6'b010010: res = bus.lo_out;
                6'b011001: begin wb_c = 1'b0; md_mul = 1'b1; end
                6'b011011: begin wb_c = 1'b0; md_div = 1'b1; end
                default:   wb_c = 1'b0;
            endcase
        end else begin
            dest = bus.rt_in;
            case (bus.opcode_in)
                6'b001001: res = a + sext;
                6'b001010: res = {{(w-1){1'b0}}, $signed(a) < $signed(sext)};
                6'b001100: res = a & zext;
                6'b001101: res = a | zext;
                6'b001110: res = a ^ zext;
                6'b001111: res = w'({bus.imm_in[15:0], 16'h0000});
                6'b000100: begin wb_c = 1'b0; is_br = 1'b1; bt_c = a == b; end
                6'b000101: begin wb_c = 1'b0; is_br = 1'b1; bt_c = a != b; end
                6'b000010: begin wb_c = 1'b0; is_j = 1'b1; bt_c = 1'b1; end
                default:   wb_c = 1'b0;
            endcase
        end
        wb_c = wb_c && dest != 5'd0;
    end
    always_comb begin
        state_n = busy ? (last ? DONE : state)
                : (accept && md_mul) ? MUL : (accept && md_div) ? DIV : IDLE;
    end
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_n;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            pr                <= '0;
            md_b              <= '0;
            cnt               <= '0;
            bus.result_out    <= '0;
            bus.dest_out      <= '0;
            bus.wb_out        <= 1'b0;
            bus.pc_out        <= '0;
            bus.branch_taken  <= 1'b0;
            bus.branch_target <= '0;
            bus.stall         <= 1'b0;
            bus.hi_out        <= '0;
            bus.lo_out        <= '0;
        end else begin
            bus.stall <= state_n == MUL || state_n == DIV;
            if (busy) begin
                pr  <= pr_n;
                cnt <= cnt + cw'(1);
            end
            if (last) begin
                bus.hi_out <= pr_n[2*w-1:w];
                bus.lo_out <= pr_n[w-1:0];
            end
            if (accept) begin
                bus.result_out   <= res;
                bus.dest_out     <= dest;
                bus.wb_out       <= wb_c;
                bus.pc_out       <= bus.pc_in;
                bus.branch_taken <= bt_c;
                if (is_br || is_j)
                    bus.branch_target <= is_j ? jtgt : btgt;
                if (md_mul || md_div) begin
                    pr   <= {{w{1'b0}}, md_mul ? b : a};
                    md_b <= md_mul ? a : b;
                    cnt  <= '0;
                end
            end else begin
                bus.wb_out       <= 1'b0;
                bus.branch_taken <= 1'b0;
            end
        end
    end
endmodule
